// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Splits one LB/LH/LW/LBU/LHU/SB/SH/SW into
// bus-aligned beats on a req/gnt/rvalid port BUS_BYTES wide, and stalls the
// pipeline until the access is complete. Non-memory instructions pass
// straight through.

// One byte lane of the bus: works out whether this lane carries an access
// byte in the current beat, which access byte it is, and the store byte.
module mem_lsu_lane #(
  parameter int BUS_BYTES = 1,
  parameter int LANE      = 0
) (
  input  logic [2:0]  beat,
  input  logic [1:0]  off,
  input  logic [2:0]  nbytes,
  input  logic [31:0] sdata,
  output logic        used,
  output logic [1:0]  idx,
  output logic [7:0]  wbyte
);
  // absolute byte position of this lane, counted from the first beat base
  logic [4:0] pos;

  // lane geometry: access byte i sits at position off+i
  always_comb begin
    pos   = 5'(beat) * 5'(BUS_BYTES) + 5'(LANE);
    used  = (pos >= 5'(off)) && (pos < 5'(off) + 5'(nbytes));
    idx   = 2'(pos - 5'(off));
    wbyte = used ? sdata[8*idx +: 8] : 8'h00;
  end
endmodule

module mem_lsu #(
  parameter int ADDR_W         = 32,
  parameter int BUS_BYTES      = 1,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [1:0]             size_i,
  input  logic                   unsigned_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [31:0]            data_i,
  input  logic [4:0]             wd_i,
  input  logic                   wreg_i,
  output logic [4:0]             wd_o,
  output logic                   wreg_o,
  output logic [31:0]            data_o,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [BUS_BYTES-1:0]   mem_be_o,
  output logic [8*BUS_BYTES-1:0] mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [8*BUS_BYTES-1:0] mem_rdata_i
);
  localparam int SH = $clog2(BUS_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [4:0]        wd;
    logic              wreg;
  } lsu_req_t;

  state_t      state;
  lsu_req_t    cap;
  logic [2:0]  beat;
  logic        trap;
  logic [31:0] result;

  logic [2:0]        nbytes;
  logic [1:0]        off;
  logic [3:0]        span;
  logic              last_beat;
  logic [ADDR_W-1:0] base;
  logic              mis_in;
  logic [31:0]       load_ext;

  logic [BUS_BYTES-1:0]       lane_used;
  logic [BUS_BYTES-1:0][1:0]  lane_idx;
  logic [BUS_BYTES-1:0][7:0]  lane_wb;

  // geometry of the captured access; span is the last byte position, so
  // span >> SH is the index of the final beat
  always_comb begin
    nbytes    = (cap.size == 2'b00) ? 3'd1 : (cap.size == 2'b01) ? 3'd2 : 3'd4;
    off       = cap.addr[1:0] & 2'(BUS_BYTES - 1);
    span      = 4'(off) + 4'(nbytes) - 4'd1;
    last_beat = (beat == 3'(span >> SH));
    base      = cap.addr & ~ADDR_W'(BUS_BYTES - 1);
    mis_in    = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
  end

  for (genvar l = 0; l < BUS_BYTES; l++) begin : g_lane
    mem_lsu_lane #(.BUS_BYTES(BUS_BYTES), .LANE(l)) u_lane (
      .beat   (beat),
      .off    (off),
      .nbytes (nbytes),
      .sdata  (cap.data),
      .used   (lane_used[l]),
      .idx    (lane_idx[l]),
      .wbyte  (lane_wb[l])
    );
  end

  // access sequencer: capture, issue one beat at a time, collect read lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cap    <= '0;
      beat   <= '0;
      trap   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          cap    <= '{we: we_i, size: size_i, uns: unsigned_i, addr: addr_i,
                      data: data_i, wd: wd_i, wreg: wreg_i};
          beat   <= '0;
          result <= '0;
          trap   <= !ALLOW_MISALIGN && mis_in;
          state  <= (!ALLOW_MISALIGN && mis_in) ? DONE : REQ;
        end
        REQ: if (mem_gnt_i) begin
          if (!cap.we)        state <= WAIT;
          else if (last_beat) state <= DONE;
          else                beat  <= beat + 3'd1;
        end
        WAIT: if (mem_rvalid_i) begin
          for (int l = 0; l < BUS_BYTES; l++)
            if (lane_used[l]) result[8*lane_idx[l] +: 8] <= mem_rdata_i[8*l +: 8];
          if (last_beat) state <= DONE;
          else begin
            beat  <= beat + 3'd1;
            state <= REQ;
          end
        end
        DONE: begin
          trap  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sign/zero extension of the assembled load bytes
  always_comb begin
    case (cap.size)
      2'b00:   load_ext = {{24{~cap.uns & result[7]}},  result[7:0]};
      2'b01:   load_ext = {{16{~cap.uns & result[15]}}, result[15:0]};
      default: load_ext = result;
    endcase
  end

  // writeback-side outputs; everything is held at 0 while reset is asserted
  always_comb begin
    stall_o = 1'b0;
    data_o  = '0;
    wd_o    = '0;
    wreg_o  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          data_o  = data_i;
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          stall_o = req_i;
        end
        REQ, WAIT: begin
          stall_o = 1'b1;
          wd_o    = cap.wd;
        end
        DONE: begin
          wd_o   = cap.wd;
          wreg_o = cap.wreg & ~trap;
          data_o = (cap.we || trap) ? 32'h0 : load_ext;
        end
        default: ;
      endcase
    end
  end

  // bus side is decoded purely from registered state, so it holds steady
  // across any number of gnt wait cycles
  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = mem_req_o & cap.we;
  assign mem_addr_o  = base + (ADDR_W'(beat) << SH);
  assign mem_be_o    = mem_req_o ? lane_used : '0;
  assign mem_wdata_o = lane_wb;
  assign misalign_o  = (state == DONE) & trap;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: four instances (bus 4/1/2 bytes, plus 4 bytes with
// misalignment trapping), driven one at a time against a byte-array memory
// model and a per-access reference computed from byte positions.
module tb_mem_lsu;
  localparam int NCFG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCFG-1:0] req;
  logic            we, uns, wreg, gnt, rvalid;
  logic [1:0]      size;
  logic [31:0]     addr, data, rdata;
  logic [4:0]      wd;

  logic [NCFG-1:0]       stall_a, wreg_a, mis_a, mreq_a, mwe_a;
  logic [NCFG-1:0][4:0]  wd_a;
  logic [NCFG-1:0][31:0] data_a, maddr_a, mwd_a;
  logic [NCFG-1:0][3:0]  be_a;

  logic [7:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  function automatic int bb_of(input int c);
    case (c)
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit am_of(input int c);
    return c != 3;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int BB = (g == 1) ? 1 : (g == 2) ? 2 : 4;
    localparam bit AM = (g != 3);
    logic [BB-1:0]   be_w;
    logic [8*BB-1:0] wdat_w;
    mem_lsu #(.ADDR_W(32), .BUS_BYTES(BB), .ALLOW_MISALIGN(AM)) u_dut (
      .clk(clk), .rst(rst), .req_i(req[g]), .we_i(we), .size_i(size),
      .unsigned_i(uns), .addr_i(addr), .data_i(data), .wd_i(wd), .wreg_i(wreg),
      .wd_o(wd_a[g]), .wreg_o(wreg_a[g]), .data_o(data_a[g]), .stall_o(stall_a[g]),
      .misalign_o(mis_a[g]), .mem_req_o(mreq_a[g]), .mem_we_o(mwe_a[g]),
      .mem_addr_o(maddr_a[g]), .mem_be_o(be_w), .mem_wdata_o(wdat_w),
      .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata[8*BB-1:0])
    );
    assign be_a[g]  = 4'(be_w);
    assign mwd_a[g] = 32'(wdat_w);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem[10'(a + 32'(i))] = v[8*i +: 8];
  endtask

  // One access on instance c. gd/rdl < 0 pick random gnt/rvalid delays.
  // Entered between posedges (at least 1 time unit after one).
  task automatic run_op(input int c, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input bit wr, input int gd, input int rdl);
    int bb, n, off, nb, k, stalls, delays, gw, rw, p, kk;
    bit trap, pend, done;
    logic [31:0] base, ev, m;
    logic [31:0] e_addr [4];
    logic [3:0]  e_be   [4];
    logic [31:0] e_wd   [4];
    bb   = bb_of(c);
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]) % bb;
    base = a - 32'(off);
    nb   = (off + n + bb - 1) / bb;
    trap = !am_of(c) && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
    for (int j = 0; j < 4; j++) begin
      e_addr[j] = base + 32'(j * bb);
      e_be[j]   = '0;
      e_wd[j]   = '0;
    end
    ev = '0;
    for (int i = 0; i < n; i++) begin
      p = off + i;
      e_be[p / bb][p % bb]        = 1'b1;
      e_wd[p / bb][8*(p % bb) +: 8] = d[8*i +: 8];
      ev[8*i +: 8]                = mem[10'(a + 32'(i))];
    end
    if (!u && n < 4 && ev[8*n-1]) ev = ev | ~((32'h1 << (8*n)) - 32'h1);
    if (w || trap) ev = '0;

    we = w; size = sz; uns = u; addr = a; data = d; wd = rd; wreg = wr;
    gnt = 1'b0; rvalid = 1'b0;
    req = '0; req[c] = 1'b1;
    #1;
    k = 0; stalls = 0; delays = 0; pend = 0; rw = 0; done = 0;
    gw = (gd < 0) ? int'($urandom_range(0, 2)) : gd;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (!stall_a[c]) done = 1;
      else begin
        stalls++;
        gnt = 1'b0; rvalid = 1'b0;
        kk = (k < 4) ? k : 3;
        if (pend) begin
          chk("one_outstanding", 32'(mreq_a[c]), 32'd0);
          if (rw == 0) begin
            rvalid = 1'b1;
            for (int l = 0; l < 4; l++) rdata[8*l +: 8] = mem[10'(e_addr[kk] + 32'(l))];
            pend = 0;
            k++;
            gw = (gd < 0) ? int'($urandom_range(0, 2)) : gd;
          end else begin
            rw--; delays++;
            rdata = $urandom;
          end
        end else if (mreq_a[c]) begin
          chk("beat_in_range", 32'(k < nb && !trap), 32'd1);
          chk("beat_addr", maddr_a[c], e_addr[kk]);
          chk("beat_be", 32'(be_a[c]), 32'(e_be[kk]));
          chk("beat_we", 32'(mwe_a[c]), 32'(w));
          if (w) begin
            m = '0;
            for (int l = 0; l < 4; l++) if (e_be[kk][l]) m[8*l +: 8] = 8'hFF;
            chk("beat_wdata", mwd_a[c] & m, e_wd[kk]);
          end
          if (gw > 0) begin
            gw--; delays++;
          end else begin
            gnt = 1'b1;
            if (w) begin
              for (int l = 0; l < bb; l++)
                if (be_a[c][l]) mem[10'(maddr_a[c] + 32'(l))] = mwd_a[c][8*l +: 8];
              k++;
              gw = (gd < 0) ? int'($urandom_range(0, 2)) : gd;
            end else begin
              pend = 1;
              rw = (rdl < 0) ? int'($urandom_range(0, 2)) : rdl;
            end
          end
        end
        @(posedge clk); #2;
      end
    end
    chk("done_reached", 32'(stall_a[c]), 32'd0);
    chk("stall_cycles", 32'(stalls),
        trap ? 32'd1 : 32'(1 + nb + (w ? 0 : nb) + delays));
    chk("beats", 32'(k), trap ? 32'd0 : 32'(nb));
    chk("done_data", data_a[c], ev);
    chk("done_wreg", 32'(wreg_a[c]), 32'(wr && !trap));
    chk("done_wd", 32'(wd_a[c]), 32'(rd));
    chk("done_misalign", 32'(mis_a[c]), 32'(trap));
    chk("done_noreq", 32'(mreq_a[c]), 32'd0);
    req = '0; gnt = 1'b0; rvalid = 1'b0;
    @(posedge clk); #2;
    chk("after_misalign", 32'(mis_a[c]), 32'd0);
    chk("after_idle", 32'(stall_a[c]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    req = '1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h100;
    data = 32'hDEAD_BEEF; wd = 5'd5; wreg = 1'b1;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;

    // reset: outputs forced low even with a request pending
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    for (int c = 0; c < NCFG; c++) begin
      chk("rst_stall", 32'(stall_a[c]), 32'd0);
      chk("rst_data", data_a[c], 32'd0);
      chk("rst_wreg", 32'(wreg_a[c]), 32'd0);
      chk("rst_wd", 32'(wd_a[c]), 32'd0);
      chk("rst_req", 32'(mreq_a[c]), 32'd0);
      chk("rst_be", 32'(be_a[c]), 32'd0);
      chk("rst_mis", 32'(mis_a[c]), 32'd0);
    end
    req = '0;
    rst = 1'b0;
    @(posedge clk); #2;

    // non-memory pass-through
    data = 32'h55; wd = 5'd7; wreg = 1'b1; #1;
    for (int c = 0; c < NCFG; c++) begin
      chk("pt_data", data_a[c], 32'h55);
      chk("pt_wd", 32'(wd_a[c]), 32'd7);
      chk("pt_wreg", 32'(wreg_a[c]), 32'd1);
      chk("pt_stall", 32'(stall_a[c]), 32'd0);
    end

    // aligned LW, bus 4
    set_word(32'h100, 32'h8000_00FF);
    run_op(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 0, 0);
    // LH across a beat boundary, signed then unsigned
    set_word(32'h100, 32'hAA00_0000);
    set_word(32'h104, 32'h0000_0081);
    run_op(0, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1, 0, 0);
    run_op(0, 1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 5'd4, 1'b1, 0, 0);
    // SW over a byte-wide bus, then read it back
    run_op(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 5'd0, 1'b0, 0, 0);
    run_op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd9, 1'b1, 0, 1);
    chk("sw_readback", data_a[0], 32'h0);
    // LB on a 2-byte bus with gnt held off 3 cycles
    mem[10'h11] = 8'h80;
    run_op(2, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 5'd6, 1'b1, 3, 0);
    // trapped misaligned LW
    run_op(3, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd8, 1'b1, 0, 0);
    // word split across the top of the address space
    run_op(0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 5'd2, 1'b1, -1, -1);

    // reset in the middle of a read
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h200; data = 32'h0;
    wd = 5'd1; wreg = 1'b1; req = '0; req[0] = 1'b1;
    #1;
    @(posedge clk); #2;
    chk("rw_req", 32'(mreq_a[0]), 32'd1);
    gnt = 1'b1;
    @(posedge clk); #2;
    gnt = 1'b0;
    chk("rw_wait_stall", 32'(stall_a[0]), 32'd1);
    chk("rw_wait_noreq", 32'(mreq_a[0]), 32'd0);
    rst = 1'b1; #1;
    chk("rw_rst_stall", 32'(stall_a[0]), 32'd0);
    chk("rw_rst_wreg", 32'(wreg_a[0]), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; req = '0; data = 32'h55; wd = 5'd7; #1;
    chk("rw_idle_req", 32'(mreq_a[0]), 32'd0);
    chk("rw_idle_stall", 32'(stall_a[0]), 32'd0);
    chk("rw_idle_data", data_a[0], 32'h55);
    req[0] = 1'b1; #1;
    chk("rw_stall_follows", 32'(stall_a[0]), 32'd1);
    req = '0; #1;

    // random mix over all instances
    for (int t = 0; t < 80; t++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                        : 32'($urandom_range(0, 1023));
      run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ra, $urandom,
             5'($urandom), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
